// File: rtl/io_port_pkg.sv
// io_port_pkg
//   Shared constants and select-range helpers for the Nibbler I/O port bank.
//   The port select is the instruction operand:
//     0 .. NUM_IN-1         -> read synchronised input data of a port
//     NUM_IN .. 2*NUM_IN-1  -> read (and clear) a port's sticky edge flags
package io_port_pkg;

    localparam int IO_DATA_W  = 4;
    localparam int IO_NUM_IN  = 3;
    localparam int IO_NUM_OUT = 3;

    function automatic logic is_data_sel(input int unsigned sel, input int unsigned num_in);
        return sel < num_in;
    endfunction

    function automatic logic is_flag_sel(input int unsigned sel, input int unsigned num_in);
        return (sel >= num_in) && (sel < 2 * num_in);
    endfunction

endpackage

// File: rtl/io_port_sync.sv
// io_port_sync
//   One input port: SYNC_STAGES-deep synchroniser, previous-sample register,
//   rising-edge detect and sticky per-bit edge flags.
// Ports:
//   clk, reset  - clock, async active-high reset
//   pins        - asynchronous input pins of this port
//   set_en      - allows rises to set flags (low during warm-up)
//   clr         - clear all flags of this port at this edge (flag read)
//   sync        - last synchroniser stage
//   rise        - sync & ~prev (combinational)
//   flags       - sticky rising-edge flags
module io_port_sync
    import io_port_pkg::*;
#(
    parameter int DATA_W      = IO_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pins,
    input  logic              set_en,
    input  logic              clr,
    output logic [DATA_W-1:0] sync,
    output logic [DATA_W-1:0] rise,
    output logic [DATA_W-1:0] flags
);

    // chain[0] is the flop nearest the pins, chain[SYNC_STAGES-1] is sync
    logic [SYNC_STAGES-1:0][DATA_W-1:0] chain;
    logic [DATA_W-1:0]                  prev;
    logic [DATA_W-1:0]                  flags_nxt;

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;

    // Clear first, then set: a rise in the same cycle as a read survives
    assign flags_nxt = (clr ? '0 : flags) | (set_en ? rise : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            prev  <= '0;
            flags <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pins};
            prev  <= sync;
            flags <= flags_nxt;
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank
//   Parametrised I/O port bank: synchronised inputs with sticky rising-edge
//   flags (clear-on-read, irq) and registered output latches.
// Ports:
//   clk, reset   - clock, async active-high reset
//   notOeIN      - active-low read strobe
//   notLoadOut   - active-low output-load strobe
//   port_sel     - port select (instruction operand)
//   bus_wr_data  - data bus value latched on a write
//   in_pins      - async input pins, port k = [k*DATA_W +: DATA_W]
//   rd_data      - read data for the bus driver
//   rd_en        - bus driver enable
//   out_pins     - output latches, port k = [k*DATA_W +: DATA_W]
//   edge_flags   - sticky rising-edge flags, same layout as in_pins
//   irq          - OR of all edge flags
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int DATA_W      = IO_DATA_W,
    parameter int NUM_IN      = IO_NUM_IN,
    parameter int NUM_OUT     = IO_NUM_OUT,
    parameter int SEL_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      notOeIN,
    input  logic                      notLoadOut,
    input  logic [SEL_W-1:0]          port_sel,
    input  logic [DATA_W-1:0]         bus_wr_data,
    input  logic [NUM_IN*DATA_W-1:0]  in_pins,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_en,
    output logic [NUM_OUT*DATA_W-1:0] out_pins,
    output logic [NUM_IN*DATA_W-1:0]  edge_flags,
    output logic                      irq
);

    // Flags are blocked for SYNC_STAGES+1 edges after reset so that pins
    // already high when reset releases do not register as edges.
    localparam int WARM_N = SYNC_STAGES + 1;
    localparam int CNT_W  = $clog2(WARM_N + 1);

    logic [CNT_W-1:0] warm_cnt;
    logic             warm_done;

    logic [NUM_IN-1:0][DATA_W-1:0]  in_arr;
    logic [NUM_IN-1:0][DATA_W-1:0]  sync_all;
    logic [NUM_IN-1:0][DATA_W-1:0]  rise_all;
    logic [NUM_IN-1:0][DATA_W-1:0]  flag_all;
    logic [NUM_IN-1:0]              clr;
    logic [NUM_OUT-1:0][DATA_W-1:0] out_q;
    logic                           irq_nxt;

    assign in_arr     = in_pins;
    assign edge_flags = flag_all;
    assign out_pins   = out_q;
    assign warm_done  = (warm_cnt == CNT_W'(WARM_N));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            warm_cnt <= '0;
        else if (!warm_done)
            warm_cnt <= warm_cnt + CNT_W'(1);
    end

    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        assign clr[k] = !notOeIN && (port_sel == SEL_W'(NUM_IN + k));

        io_port_sync #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .reset  (reset),
            .pins   (in_arr[k]),
            .set_en (warm_done),
            .clr    (clr[k]),
            .sync   (sync_all[k]),
            .rise   (rise_all[k]),
            .flags  (flag_all[k])
        );
    end

    // irq tracks the flags' next state so it changes on the same edge
    always_comb begin
        irq_nxt = 1'b0;
        for (int k = 0; k < NUM_IN; k++)
            irq_nxt = irq_nxt | (|((clr[k] ? '0 : flag_all[k]) |
                                   (warm_done ? rise_all[k] : '0)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= irq_nxt;
    end

    // Read decode: purely combinational, a same-cycle write cannot affect it
    always_comb begin
        rd_data = '0;
        rd_en   = 1'b0;
        if (!notOeIN && !reset) begin
            rd_en = is_data_sel(32'(port_sel), NUM_IN) ||
                    is_flag_sel(32'(port_sel), NUM_IN);
            for (int k = 0; k < NUM_IN; k++) begin
                if (port_sel == SEL_W'(k))
                    rd_data = sync_all[k];
                if (port_sel == SEL_W'(NUM_IN + k))
                    rd_data = flag_all[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++)
                if (!notLoadOut && (port_sel == SEL_W'(k)))
                    out_q[k] <= bus_wr_data;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank
//   Directed bench for io_port_bank with a scoreboard queue: expected values
//   are queued when stimulus is applied and popped when outputs are sampled.
module tb_io_port_bank;

    localparam int DATA_W      = 4;
    localparam int NUM_IN      = 3;
    localparam int NUM_OUT     = 3;
    localparam int SEL_W       = 4;
    localparam int SYNC_STAGES = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      notOeIN;
    logic                      notLoadOut;
    logic [SEL_W-1:0]          port_sel;
    logic [DATA_W-1:0]         bus_wr_data;
    logic [NUM_IN*DATA_W-1:0]  in_pins;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_en;
    logic [NUM_OUT*DATA_W-1:0] out_pins;
    logic [NUM_IN*DATA_W-1:0]  edge_flags;
    logic                      irq;

    io_port_bank #(
        .DATA_W      (DATA_W),
        .NUM_IN      (NUM_IN),
        .NUM_OUT     (NUM_OUT),
        .SEL_W       (SEL_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .notOeIN     (notOeIN),
        .notLoadOut  (notLoadOut),
        .port_sel    (port_sel),
        .bus_wr_data (bus_wr_data),
        .in_pins     (in_pins),
        .rd_data     (rd_data),
        .rd_en       (rd_en),
        .out_pins    (out_pins),
        .edge_flags  (edge_flags),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic exp_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_check(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val)
            else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        notOeIN     = 1'b0;
        notLoadOut  = 1'b1;
        port_sel    = '0;
        bus_wr_data = '0;
        in_pins     = 12'h00F;

        // ---- 1: reset with port0 held high ----
        repeat (3) tick();
        exp_push("rst_rd_en", 32'd0);       exp_check(32'(rd_en));
        exp_push("rst_flags", 32'h0);       exp_check(32'(edge_flags));
        exp_push("rst_out", 32'h0);         exp_check(32'(out_pins));
        exp_push("rst_irq", 32'd0);         exp_check(32'(irq));
        reset   = 1'b0;
        notOeIN = 1'b1;
        repeat (10) tick();
        exp_push("warm_flags", 32'h0);      exp_check(32'(edge_flags));
        exp_push("warm_irq", 32'd0);        exp_check(32'(irq));
        exp_push("warm_out", 32'h0);        exp_check(32'(out_pins));
        exp_push("oe_off_rd_en", 32'd0);    exp_check(32'(rd_en));
        notOeIN  = 1'b0;
        port_sel = 4'd0;
        #1;
        exp_push("rd_p0_data", 32'hF);      exp_check(32'(rd_data));
        exp_push("rd_p0_en", 32'd1);        exp_check(32'(rd_en));

        // ---- 2: port1 0 -> 0101, reading data range ----
        port_sel = 4'd1;
        in_pins  = 12'h05F;
        tick();
        exp_push("sync_c1", 32'h0);         exp_check(32'(rd_data));
        tick();
        exp_push("sync_c2", 32'h5);         exp_check(32'(rd_data));
        exp_push("flags_c2", 32'h000);      exp_check(32'(edge_flags));
        tick();
        exp_push("flags_c3", 32'h050);      exp_check(32'(edge_flags));
        exp_push("irq_c3", 32'd1);          exp_check(32'(irq));
        tick();
        exp_push("data_rd_no_clr", 32'h050); exp_check(32'(edge_flags));

        // ---- 3: flag read clears ----
        port_sel = 4'd4;
        #1;
        exp_push("flag_rd", 32'h5);         exp_check(32'(rd_data));
        exp_push("flag_rd_en", 32'd1);      exp_check(32'(rd_en));
        tick();
        exp_push("flag_clr", 32'h000);      exp_check(32'(edge_flags));
        exp_push("irq_clr", 32'd0);         exp_check(32'(irq));
        exp_push("flag_rd_again", 32'h0);   exp_check(32'(rd_data));

        // ---- 4: flag read racing a new rise on bit3 ----
        notOeIN = 1'b1;
        in_pins = 12'h00F;
        repeat (3) tick();
        exp_push("fall_no_flag", 32'h000);  exp_check(32'(edge_flags));
        in_pins = 12'h05F;
        repeat (3) tick();
        exp_push("reflag", 32'h050);        exp_check(32'(edge_flags));
        in_pins = 12'h0DF;
        repeat (2) tick();
        notOeIN  = 1'b0;
        port_sel = 4'd4;
        #1;
        exp_push("race_rd", 32'h5);         exp_check(32'(rd_data));
        tick();
        exp_push("race_flags", 32'h080);    exp_check(32'(edge_flags));
        exp_push("race_irq", 32'd1);        exp_check(32'(irq));
        exp_push("race_next_rd", 32'h8);    exp_check(32'(rd_data));
        tick();
        notOeIN = 1'b1;

        // ---- 5: output latches ----
        notLoadOut  = 1'b0;
        port_sel    = 4'd1;
        bus_wr_data = 4'h6;
        tick();
        port_sel    = 4'd2;
        bus_wr_data = 4'hA;
        tick();
        exp_push("wr_p2", 32'hA60);         exp_check(32'(out_pins));
        port_sel    = 4'd7;
        bus_wr_data = 4'hF;
        tick();
        port_sel    = 4'd3;
        tick();
        exp_push("wr_oob", 32'hA60);        exp_check(32'(out_pins));
        notLoadOut = 1'b1;
        notOeIN    = 1'b0;
        port_sel   = 4'd9;
        #1;
        exp_push("rd_oob_en", 32'd0);       exp_check(32'(rd_en));
        exp_push("rd_oob_data", 32'h0);     exp_check(32'(rd_data));
        port_sel = 4'd6;
        #1;
        exp_push("rd_sel6_en", 32'd0);      exp_check(32'(rd_en));

        // ---- 6: simultaneous read and write, then async reset ----
        port_sel    = 4'd0;
        notLoadOut  = 1'b0;
        bus_wr_data = 4'h3;
        #1;
        exp_push("rw_rd_pre", 32'hF);       exp_check(32'(rd_data));
        tick();
        exp_push("rw_out", 32'hA63);        exp_check(32'(out_pins));
        exp_push("rw_rd_post", 32'hF);      exp_check(32'(rd_data));
        notLoadOut = 1'b1;
        in_pins    = 12'h1DF;
        repeat (3) tick();
        exp_push("p2_flag", 32'h100);       exp_check(32'(edge_flags));
        exp_push("p2_irq", 32'd1);          exp_check(32'(irq));
        #2;
        reset = 1'b1;
        #1;
        exp_push("async_out", 32'h0);       exp_check(32'(out_pins));
        exp_push("async_flags", 32'h0);     exp_check(32'(edge_flags));
        exp_push("async_irq", 32'd0);       exp_check(32'(irq));
        exp_push("async_rd_en", 32'd0);     exp_check(32'(rd_en));
        tick();
        reset = 1'b0;
        repeat (10) tick();
        exp_push("rewarm_flags", 32'h0);    exp_check(32'(edge_flags));
        exp_push("rewarm_irq", 32'd0);      exp_check(32'(irq));
        port_sel = 4'd2;
        #1;
        exp_push("rewarm_p2", 32'h1);       exp_check(32'(rd_data));

        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
